fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the branch stage.
- Holds the program counter and issues single-outstanding requests to instruction memory.
- Buffers the returned 16-bit instruction and presents it to decode/branch logic with a valid/ready handshake.
- Accepts PC redirects from the branch stage and squashes any fetch already in flight.

Parameters:
RESET_PC, 0, PC value loaded on reset
ADDR_W, 12, PC/address width (matches branch target field instruction[15:4])
INSTR_W, 16, instruction width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  branch stage requests PC change this cycle
redirect_pc  in  ADDR_W  new PC when redirect_valid
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  ADDR_W  fetch address
imem_rsp_valid  in  1  response data valid (one per accepted request, at least 1 cycle after acceptance)
imem_rsp_data  in  INSTR_W  fetched instruction
instr_valid  out  1  instruction available to downstream
instr_ready  in  1  downstream accepts instruction
instruction  out  INSTR_W  buffered instruction
instr_pc  out  ADDR_W  address the buffered instruction came from
fetch_count  out  16  count of completed instruction transfers (wraps at 0xFFFF -> 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. During reset and on the first cycle after it:
  - pc=RESET_PC
  - state=IDLE
  - all outputs 0: instruction=0, instr_pc=0, fetch_count=0
- Output decode:
  - imem_req_valid=(state==REQ); imem_addr=pc.
  - instr_valid=(state==HOLD) & !redirect_valid. This is combinational: a redirect suppresses the transfer in the same cycle.
- States: IDLE, REQ, WAIT, DRAIN, HOLD.
- IDLE:
  - No redirect -> REQ.
  - Redirect -> pc<=redirect_pc, then REQ.
- REQ:
  - Redirect with !imem_req_ready -> pc<=redirect_pc, stay REQ (nothing accepted).
  - Redirect with imem_req_ready -> pc<=redirect_pc, then DRAIN (stale request accepted, must be discarded).
  - Ready without redirect -> instr_pc<=pc, pc<=pc+1 mod 2^ADDR_W (0xFFF wraps to 0x000), then WAIT.
- WAIT:
  - rsp_valid without redirect -> instruction<=imem_rsp_data, then HOLD.
  - Redirect -> pc<=redirect_pc. If rsp_valid is high the same cycle, discard the response and go to REQ; otherwise go to DRAIN.
- DRAIN:
  - Wait for rsp_valid, discard the data, then REQ.
  - Redirect in DRAIN -> pc<=redirect_pc; the rsp_valid rule is unchanged (a later redirect overwrites an earlier one).
- HOLD:
  - instruction and instr_pc remain stable while instr_valid & !instr_ready.
  - instr_valid & instr_ready -> fetch_count+1, then REQ.
  - Redirect -> pc<=redirect_pc, buffer dropped (no count), then REQ.
- Throughput and latency:
  - Maximum one outstanding request, so peak throughput is one instruction per 3 cycles with zero-wait memory.
  - Latency from reset release to first imem_req_valid is 1 cycle.
- Memory interface rules:
  - imem_addr may change while imem_req_valid=1 only on a redirect cycle.
  - imem_rsp_valid in IDLE, REQ or HOLD is a protocol error. It is ignored, and an assertion fires in simulation.
- Mid-operation reset: reset in any state returns to the reset values next cycle. Any outstanding memory response arriving after that is ignored; the memory is reset alongside.

Test Plan:
1. Reset release, RESET_PC=0, imem_req_ready=1, 1-cycle memory returning data=addr+0x100, instr_ready=1 -> requests to 0,1,2. instructions 0x0100,0x0101,0x0102 with instr_pc 0,1,2. fetch_count=3 after 9 cycles.
2. Backpressure: instr_ready=0 for 5 cycles in HOLD -> instruction/instr_pc stable, no new imem_req_valid. On instr_ready=1, fetch_count increments exactly once.
3. Redirect in WAIT to 0x040 with response 2 cycles later -> stale response discarded. Next request at 0x040; its instruction is delivered with instr_pc=0x040.
4. Redirect in HOLD with instr_ready=1 same cycle -> instr_valid=0 that cycle, fetch_count unchanged. Next imem_addr=redirect_pc.
5. Wrap: redirect to 0xFFF -> fetch from 0xFFF then 0x000, instr_pc 0xFFF then 0x000.
6. Reset asserted in WAIT -> next cycle state IDLE, all outputs 0, pc=RESET_PC. A late imem_rsp_valid is ignored, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory and buffers the returned instruction for the branch stage.
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [15:0]        fetch_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic [15:0]          r_count;

  state_t               w_state_next;
  logic [ADDR_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0]   w_instr_next;
  logic [ADDR_W-1:0]    w_instr_pc_next;
  logic [15:0]          w_count_next;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_count_next    = r_count;
    // A redirect always takes the PC, whatever the state does with it.
    if (redirect_valid) w_pc_next = redirect_pc;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        if (redirect_valid) begin
          if (imem_req_ready) w_state_next = DRAIN;
        end else if (imem_req_ready) begin
          w_instr_pc_next = r_pc;
          w_pc_next       = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_state_next    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_state_next = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          w_instr_next = imem_rsp_data;
          w_state_next = HOLD;
        end
      end
      DRAIN: if (imem_rsp_valid) w_state_next = REQ;
      HOLD: begin
        if (redirect_valid) begin
          w_state_next = REQ;
        end else if (instr_ready) begin
          w_count_next = r_count + 16'd1;
          w_state_next = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_count    <= w_count_next;
    end
  end

  assign imem_req_valid = (r_state == REQ);
  assign imem_addr      = r_pc;
  assign instr_valid    = (r_state == HOLD) && !redirect_valid;
  assign instruction    = r_instr;
  assign instr_pc       = r_instr_pc;
  assign fetch_count    = r_count;

  // Responses are only legal while a request is outstanding.
  a_rsp_protocol: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (r_state == WAIT || r_state == DRAIN));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle stimulus/expectation vectors plus a
// hand-written backpressure sequence.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [11:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [11:0] instr_pc;
  logic [15:0] fetch_count;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(.ADDR_W(12), .INSTR_W(16), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [11:0] rpc;
    logic        rdy;
    logic        rsv;
    logic [15:0] rsd;
    logic        ir;
    logic        e_rqv;
    logic [11:0] e_addr;
    logic        e_iv;
    logic [15:0] e_ins;
    logic [11:0] e_ipc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(int rst, int rv, int rpc, int rdy, int rsv, int rsd, int ir,
                              int rqv, int addr, int iv, int ins, int ipc, int cnt);
    vec_t v;
    v.rst = 1'(rst);   v.rv = 1'(rv);     v.rpc = 12'(rpc);  v.rdy = 1'(rdy);
    v.rsv = 1'(rsv);   v.rsd = 16'(rsd);  v.ir = 1'(ir);
    v.e_rqv = 1'(rqv); v.e_addr = 12'(addr); v.e_iv = 1'(iv);
    v.e_ins = 16'(ins); v.e_ipc = 12'(ipc); v.e_cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(string tag, int idx, string nm, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the outputs
  // that the DUT presents before the next rising edge.
  task automatic apply(vec_t v, string tag, int idx);
    @(negedge clk);
    reset          = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rsv;
    imem_rsp_data  = v.rsd;
    instr_ready    = v.ir;
    #1;
    chk(tag, idx, "imem_req_valid", 32'(imem_req_valid), 32'(v.e_rqv));
    chk(tag, idx, "imem_addr",      32'(imem_addr),      32'(v.e_addr));
    chk(tag, idx, "instr_valid",    32'(instr_valid),    32'(v.e_iv));
    chk(tag, idx, "instruction",    32'(instruction),    32'(v.e_ins));
    chk(tag, idx, "instr_pc",       32'(instr_pc),       32'(v.e_ipc));
    chk(tag, idx, "fetch_count",    32'(fetch_count),    32'(v.e_cnt));
    $display("[TB] %s[%0d] req=%0d addr=%03h iv=%0d ins=%04h ipc=%03h cnt=%0d",
             tag, idx, imem_req_valid, imem_addr, instr_valid, instruction, instr_pc, fetch_count);
  endtask

  initial begin
    // rst rv rpc rdy rsv rsd ir | rqv addr iv ins ipc cnt
    // Straight-line fetch of 0,1,2 with a one-cycle memory returning addr+0x100.
    tab_a.push_back(mk(1,0,0,0,0,0,0,        0,0,0,0,0,0));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        0,0,0,0,0,0));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        1,0,0,0,0,0));
    tab_a.push_back(mk(0,0,0,1,1,'h100,1,    0,1,0,0,0,0));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        0,1,1,'h100,0,0));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        1,1,0,'h100,0,1));
    tab_a.push_back(mk(0,0,0,1,1,'h101,1,    0,2,0,'h100,1,1));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        0,2,1,'h101,1,1));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        1,2,0,'h101,1,2));
    tab_a.push_back(mk(0,0,0,1,1,'h102,1,    0,3,0,'h101,2,2));
    tab_a.push_back(mk(0,0,0,1,0,0,1,        0,3,1,'h102,2,2));
    tab_a.push_back(mk(0,0,0,0,0,0,1,        1,3,0,'h102,2,3));

    // Redirect in WAIT to 0x040 with the stale response two cycles later.
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,4,0,'h103,3,4));
    tab_b.push_back(mk(0,1,'h040,0,0,0,0,    0,5,0,'h103,4,4));
    tab_b.push_back(mk(0,0,0,0,0,0,0,        0,'h40,0,'h103,4,4));
    tab_b.push_back(mk(0,0,0,0,1,'hDEAD,0,   0,'h40,0,'h103,4,4));
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,'h40,0,'h103,4,4));
    tab_b.push_back(mk(0,0,0,0,1,'h140,0,    0,'h41,0,'h103,'h40,4));
    tab_b.push_back(mk(0,0,0,0,0,0,1,        0,'h41,1,'h140,'h40,4));
    // Redirect in HOLD with instr_ready high, to 0xFFF, then wrap to 0x000.
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,'h41,0,'h140,'h40,5));
    tab_b.push_back(mk(0,0,0,0,1,'h141,0,    0,'h42,0,'h140,'h41,5));
    tab_b.push_back(mk(0,1,'hFFF,0,0,0,1,    0,'h42,0,'h141,'h41,5));
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,'hFFF,0,'h141,'h41,5));
    tab_b.push_back(mk(0,0,0,0,1,'h10FF,0,   0,0,0,'h141,'hFFF,5));
    tab_b.push_back(mk(0,0,0,0,0,0,1,        0,0,1,'h10FF,'hFFF,5));
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,0,0,'h10FF,'hFFF,6));
    tab_b.push_back(mk(0,0,0,0,1,'h100,0,    0,1,0,'h10FF,0,6));
    tab_b.push_back(mk(0,0,0,0,0,0,1,        0,1,1,'h100,0,6));
    // Reset in WAIT; late response arrives while reset is still held.
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,1,0,'h100,0,7));
    tab_b.push_back(mk(1,0,0,0,0,0,0,        0,2,0,'h100,1,7));
    tab_b.push_back(mk(1,0,0,0,1,'hBEEF,0,   0,0,0,0,0,0));
    tab_b.push_back(mk(0,0,0,1,0,0,0,        0,0,0,0,0,0));
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,0,0,0,0,0));
    tab_b.push_back(mk(0,0,0,0,1,'h100,0,    0,1,0,0,0,0));
    tab_b.push_back(mk(0,0,0,0,0,0,1,        0,1,1,'h100,0,0));
    // Redirects in REQ (not accepted / accepted) and in WAIT with same-cycle response.
    tab_b.push_back(mk(0,1,'h020,0,0,0,0,    1,1,0,'h100,0,1));
    tab_b.push_back(mk(0,1,'h030,1,0,0,0,    1,'h20,0,'h100,0,1));
    tab_b.push_back(mk(0,0,0,0,1,'h5555,0,   0,'h30,0,'h100,0,1));
    tab_b.push_back(mk(0,0,0,1,0,0,0,        1,'h30,0,'h100,0,1));
    tab_b.push_back(mk(0,1,'h050,0,1,'h6666,0, 0,'h31,0,'h100,'h30,1));
    tab_b.push_back(mk(0,0,0,0,0,0,0,        1,'h50,0,'h100,'h30,1));
    // Redirect in IDLE right after reset.
    tab_b.push_back(mk(1,0,0,0,0,0,0,        1,'h50,0,'h100,'h30,1));
    tab_b.push_back(mk(0,1,'h077,0,0,0,0,    0,0,0,0,0,0));
    tab_b.push_back(mk(0,0,0,0,0,0,0,        1,'h77,0,0,0,0));

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tab_a[i]) apply(tab_a[i], "seq", i);

    // Backpressure: five stalled HOLD cycles with memory ready, then one transfer.
    apply(mk(0,0,0,1,0,0,0,      1,3,0,'h102,2,3), "bp", 0);
    apply(mk(0,0,0,0,1,'h103,0,  0,4,0,'h102,3,3), "bp", 1);
    for (int k = 0; k < 5; k++)
      apply(mk(0,0,0,1,0,0,0,    0,4,1,'h103,3,3), "bp_stall", k);
    apply(mk(0,0,0,0,0,0,1,      0,4,1,'h103,3,3), "bp", 2);
    apply(mk(0,0,0,0,0,0,0,      1,4,0,'h103,3,4), "bp", 3);
    apply(mk(0,0,0,0,0,0,0,      1,4,0,'h103,3,4), "bp", 4);

    foreach (tab_b[i]) apply(tab_b[i], "redir", i);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
